// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port data memory.
//
// Requester 0 is the load/store unit, requester 1 the loader/debug port. A request
// seen in IDLE is granted combinationally, its address/type/data are latched at the
// clock edge and presented to the memory for exactly one ACCESS cycle. Read data is
// captured at the ACCESS-exit edge into one shared rdata register and flagged to the
// owning requester with a one-cycle rvalid pulse.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   rN_req/rN_we/rN_addr/rN_wdata    request, 1=write/0=read, byte address, write data
//   rN_gnt                           request accepted this cycle (IDLE only)
//   rN_rvalid/rN_rdata               read-data-valid pulse, shared read-data register
//   mem_address/mem_data_write       memory address and write data (0 outside ACCESS)
//   mem_MemWrite/mem_MemRead         memory strobes (ACCESS only)
//   mem_data_read                    combinational read data from the memory
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to give ties to the requester not
// granted last; otherwise requester 0 always wins ties.

module mem_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r0_req,
   input  logic             r0_we,
   input  logic [WIDTH-1:0] r0_addr,
   input  logic [WIDTH-1:0] r0_wdata,
   input  logic             r1_req,
   input  logic             r1_we,
   input  logic [WIDTH-1:0] r1_addr,
   input  logic [WIDTH-1:0] r1_wdata,
   output logic             r0_gnt,
   output logic             r1_gnt,
   output logic             r0_rvalid,
   output logic             r1_rvalid,
   output logic [WIDTH-1:0] r0_rdata,
   output logic [WIDTH-1:0] r1_rdata,
   output logic [WIDTH-1:0] mem_address,
   output logic [WIDTH-1:0] mem_data_write,
   output logic             mem_MemWrite,
   output logic             mem_MemRead,
   input  logic [WIDTH-1:0] mem_data_read
);

   typedef enum logic [0:0] {StIdle, StAccess} state_e;

   state_e           state_q;
   logic             owner_q;      // 0 = requester 0, 1 = requester 1
   logic [WIDTH-1:0] addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic             we_q;
   logic             re_q;
   logic [WIDTH-1:0] rdata_q;
   logic             rvalid0_q;
   logic             rvalid1_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic             last_grant_q; // ID of the most recent grant
`endif

   // Grant decode. Gated by rst_n so no grant is visible while reset is held.
   always_comb begin
      r0_gnt = 1'b0;
      r1_gnt = 1'b0;
      if (rst_n && (state_q == StIdle)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         if (r0_req && r1_req) begin
            r0_gnt = last_grant_q;
            r1_gnt = ~last_grant_q;
         end else begin
            r0_gnt = r0_req;
            r1_gnt = r1_req;
         end
`else
         r0_gnt = r0_req;
         r1_gnt = r1_req & ~r0_req;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         re_q         <= 1'b0;
         rdata_q      <= '0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (r0_gnt || r1_gnt) begin
                  state_q <= StAccess;
                  owner_q <= r1_gnt;
                  addr_q  <= r1_gnt ? r1_addr  : r0_addr;
                  wdata_q <= r1_gnt ? r1_wdata : r0_wdata;
                  we_q    <= r1_gnt ? r1_we    : r0_we;
                  re_q    <= r1_gnt ? ~r1_we   : ~r0_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_grant_q <= r1_gnt;
`endif
               end
            end
            StAccess: begin
               // Single-cycle access; clearing the latches also zeroes the memory port.
               state_q <= StIdle;
               addr_q  <= '0;
               wdata_q <= '0;
               we_q    <= 1'b0;
               re_q    <= 1'b0;
               if (re_q) begin
                  rdata_q   <= mem_data_read;
                  rvalid0_q <= ~owner_q;
                  rvalid1_q <= owner_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mem_address    = addr_q;
   assign mem_data_write = wdata_q;
   assign mem_MemWrite   = we_q;
   assign mem_MemRead    = re_q;
   assign r0_rvalid      = rvalid0_q;
   assign r1_rvalid      = rvalid1_q;
   assign r0_rdata       = rdata_q;
   assign r1_rdata       = rdata_q;

endmodule
